icb_rr_arbiter: RTL and testbench

- Shares the single ICB slave port of the crypto bridge top (ICB in, four APB masters out) between NUM_M ICB requesters, e.g. a CPU and a DMA.
- Arbitrates commands round-robin.
- Records which requester owns each outstanding command in an in-order tag FIFO, and routes each slave response back to its owner.
- Sits directly in front of the bridge's ICB slave port.

---
 rtl/icb_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_icb_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_rr_arbiter.sv
// Round-robin arbiter sharing one ICB slave port between NUM_M requesters.
// An in-order tag FIFO records command ownership and routes responses back.
module icb_rr_arbiter #(
   parameter int NUM_M      = 2,
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int OUTS_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_M-1:0]          m_cmd_valid,
   output logic [NUM_M-1:0]          m_cmd_ready,
   input  logic [NUM_M-1:0]          m_cmd_read,
   input  logic [NUM_M*AW-1:0]       m_cmd_addr,
   input  logic [NUM_M*DW-1:0]       m_cmd_wdata,
   input  logic [NUM_M*DW/8-1:0]     m_cmd_wmask,
   output logic [NUM_M-1:0]          m_rsp_valid,
   input  logic [NUM_M-1:0]          m_rsp_ready,
   output logic [DW-1:0]             m_rsp_rdata,
   output logic                      m_rsp_err,
   output logic                      s_cmd_valid,
   input  logic                      s_cmd_ready,
   output logic                      s_cmd_read,
   output logic [AW-1:0]             s_cmd_addr,
   output logic [DW-1:0]             s_cmd_wdata,
   output logic [DW/8-1:0]           s_cmd_wmask,
   input  logic                      s_rsp_valid,
   output logic                      s_rsp_ready,
   input  logic [DW-1:0]             s_rsp_rdata,
   input  logic                      s_rsp_err,
   output logic [$clog2(OUTS_DEPTH):0] outs_cnt,
   output logic                      unexp_rsp
);

   localparam int IDW = $clog2(NUM_M);
   localparam int PW  = $clog2(OUTS_DEPTH);
   localparam int CW  = PW + 1;

   logic [IDW-1:0]  rr_ptr;
   logic            lock;
   logic [IDW-1:0]  locked_id;
   logic [IDW-1:0]  tag_mem [OUTS_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   logic            cand_found;
   logic [IDW-1:0]  cand_id;
   logic [IDW:0]    scan_idx;
   logic            gnt_valid;
   logic [IDW-1:0]  gnt_id;
   logic            full;
   logic            empty;
   logic            cmd_hs;
   logic            rsp_hs;
   logic [IDW-1:0]  head;

   logic [AW-1:0]   addr_arr  [NUM_M];
   logic [DW-1:0]   wdata_arr [NUM_M];
   logic [DW/8-1:0] wmask_arr [NUM_M];

   always_comb begin
      for (int i = 0; i < NUM_M; i++) begin
         addr_arr[i]  = m_cmd_addr[i*AW +: AW];
         wdata_arr[i] = m_cmd_wdata[i*DW +: DW];
         wmask_arr[i] = m_cmd_wmask[i*(DW/8) +: DW/8];
      end
   end

   // Scan from rr_ptr upward, wrapping modulo NUM_M (not necessarily a power of 2).
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      cand_found = 1'b0;
      cand_id    = '0;
      scan_idx   = '0;
      for (int k = 0; k < NUM_M; k++) begin
         // NOTE: blocking assignments in combinational logic, so scan_idx is used within the same pass.
         scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan_idx >= (IDW+1)'(NUM_M)) scan_idx = scan_idx - (IDW+1)'(NUM_M);
         if (!cand_found && m_cmd_valid[scan_idx[IDW-1:0]]) begin
            cand_found = 1'b1;
            cand_id    = scan_idx[IDW-1:0];
         end
      end
   end

   assign gnt_valid = lock ? 1'b1 : cand_found;
   assign gnt_id    = lock ? locked_id : cand_id;
   assign full      = (outs_cnt == CW'(OUTS_DEPTH));
   assign empty     = (outs_cnt == '0);
   assign head      = tag_mem[rd_ptr];

   assign s_cmd_valid = gnt_valid && !full;
   assign s_cmd_read  = m_cmd_read[gnt_id];
   assign s_cmd_addr  = addr_arr[gnt_id];
   assign s_cmd_wdata = wdata_arr[gnt_id];
   assign s_cmd_wmask = wmask_arr[gnt_id];
   assign cmd_hs      = s_cmd_valid && s_cmd_ready;

   // With nothing outstanding the response is swallowed rather than stalling the bridge.
   assign s_rsp_ready = empty ? 1'b1 : m_rsp_ready[head];
   assign rsp_hs      = s_rsp_valid && s_rsp_ready && !empty;
   assign m_rsp_rdata = s_rsp_rdata;
   assign m_rsp_err   = s_rsp_err;

   always_comb begin
      m_cmd_ready = '0;
      m_rsp_valid = '0;
      for (int i = 0; i < NUM_M; i++) begin
         m_cmd_ready[i] = gnt_valid && (gnt_id == IDW'(i)) && s_cmd_ready && !full;
         m_rsp_valid[i] = !empty && s_rsp_valid && (head == IDW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         lock      <= 1'b0;
         locked_id <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         outs_cnt  <= '0;
         unexp_rsp <= 1'b0;
      end else begin
         unexp_rsp <= s_rsp_valid && empty;

         // Hold the grant while the bridge stalls so valid/payload stay stable.
         if (cmd_hs) begin
            lock   <= 1'b0;
            rr_ptr <= (gnt_id == IDW'(NUM_M-1)) ? '0 : gnt_id + 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
         end else if (s_cmd_valid) begin
            lock      <= 1'b1;
            locked_id <= gnt_id;
         end

         if (rsp_hs) rd_ptr <= rd_ptr + 1'b1;

         case ({cmd_hs, rsp_hs})
            2'b10:   outs_cnt <= outs_cnt + 1'b1;
            2'b01:   outs_cnt <= outs_cnt - 1'b1;
            default: outs_cnt <= outs_cnt;
         endcase
      end
   end

   // NOTE: tag storage has no reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (cmd_hs) tag_mem[wr_ptr] <= gnt_id;
   end

endmodule

// File: tb/tb_icb_rr_arbiter.sv
// Directed bench for icb_rr_arbiter (NUM_M=2, OUTS_DEPTH=4) with an owner-tag scoreboard.
module tb_icb_rr_arbiter;

   localparam int NUM_M = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int OD    = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_M-1:0]      m_cmd_valid;
   logic [NUM_M-1:0]      m_cmd_ready;
   logic [NUM_M-1:0]      m_cmd_read;
   logic [NUM_M*AW-1:0]   m_cmd_addr;
   logic [NUM_M*DW-1:0]   m_cmd_wdata;
   logic [NUM_M*DW/8-1:0] m_cmd_wmask;
   logic [NUM_M-1:0]      m_rsp_valid;
   logic [NUM_M-1:0]      m_rsp_ready;
   logic [DW-1:0]         m_rsp_rdata;
   logic                  m_rsp_err;
   logic                  s_cmd_valid;
   logic                  s_cmd_ready;
   logic                  s_cmd_read;
   logic [AW-1:0]         s_cmd_addr;
   logic [DW-1:0]         s_cmd_wdata;
   logic [DW/8-1:0]       s_cmd_wmask;
   logic                  s_rsp_valid;
   logic                  s_rsp_ready;
   logic [DW-1:0]         s_rsp_rdata;
   logic                  s_rsp_err;
   logic [$clog2(OD):0]   outs_cnt;
   logic                  unexp_rsp;

   int vectors = 0;
   int errors  = 0;
   int sb[$];
   logic [AW-1:0] addr_tab [NUM_M];
   int gnt_cnt [NUM_M];

   icb_rr_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .OUTS_DEPTH(OD)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_read(m_cmd_read),
      .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
      .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
      .m_rsp_err(m_rsp_err),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(s_cmd_read),
      .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
      .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
      .s_rsp_err(s_rsp_err),
      .outs_cnt(outs_cnt), .unexp_rsp(unexp_rsp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      m_cmd_read[id]              = rd;
      m_cmd_addr[id*AW +: AW]     = a;
      m_cmd_wdata[id*DW +: DW]    = wd;
      m_cmd_wmask[id*(DW/8) +: DW/8] = '1;
      addr_tab[id]                = a;
   endtask

   // Issue one command from a single requester, expecting acceptance in the same cycle.
   task automatic issue(input int id, input logic rd, input logic [AW-1:0] a);
      set_req(id, rd, a, a ^ 32'h5A5A_5A5A);
      m_cmd_valid     = '0;
      m_cmd_valid[id] = 1'b1;
      s_cmd_ready     = 1'b1;
      #1;
      check("issue_ready", 64'(m_cmd_ready), 64'(2'b01 << id));
      check("issue_addr", 64'(s_cmd_addr), 64'(a));
      sb.push_back(id);
      tick();
      m_cmd_valid = '0;
   endtask

   // Present one response and compare routing against the scoreboard head.
   task automatic respond(input logic [DW-1:0] rd);
      logic [NUM_M-1:0] exp_vld;
      s_rsp_valid = 1'b1;
      s_rsp_rdata = rd;
      #1;
      exp_vld = '0;
      if (sb.size() > 0) exp_vld = 2'b01 << sb.pop_front();
      check("rsp_route", 64'(m_rsp_valid), 64'(exp_vld));
      check("rsp_rdata", 64'(m_rsp_rdata), 64'(rd));
      tick();
      s_rsp_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      m_cmd_valid = '0;
      m_cmd_read  = '0;
      m_cmd_addr  = '0;
      m_cmd_wdata = '0;
      m_cmd_wmask = '0;
      m_rsp_ready = '1;
      s_cmd_ready = 1'b0;
      s_rsp_valid = 1'b0;
      s_rsp_rdata = '0;
      s_rsp_err   = 1'b0;
      tick();
      tick();
      check("rst_outs_cnt", 64'(outs_cnt), 64'(0));
      check("rst_s_cmd_valid", 64'(s_cmd_valid), 64'(0));
      check("rst_m_cmd_ready", 64'(m_cmd_ready), 64'(0));
      check("rst_m_rsp_valid", 64'(m_rsp_valid), 64'(0));
      check("rst_unexp", 64'(unexp_rsp), 64'(0));
      rst_n = 1'b1;
      tick();

      // Single read from requester 1
      set_req(1, 1'b1, 32'h1000_0004, 32'h0);
      m_cmd_valid = 2'b10;
      s_cmd_ready = 1'b1;
      #1;
      check("rd_s_cmd_valid", 64'(s_cmd_valid), 64'(1));
      check("rd_s_cmd_addr", 64'(s_cmd_addr), 64'(32'h1000_0004));
      check("rd_s_cmd_read", 64'(s_cmd_read), 64'(1));
      check("rd_m_cmd_ready", 64'(m_cmd_ready), 64'(2'b10));
      sb.push_back(1);
      tick();
      m_cmd_valid = '0;
      check("rd_outs_1", 64'(outs_cnt), 64'(1));
      respond(32'hDEAD_BEEF);
      check("rd_outs_0", 64'(outs_cnt), 64'(0));

      // Round-robin with both requesters valid, running into full
      set_req(0, 1'b0, 32'h0000_0100, 32'h1111_1111);
      set_req(1, 1'b0, 32'h0000_0200, 32'h2222_2222);
      gnt_cnt[0] = 0;
      gnt_cnt[1] = 0;
      m_cmd_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_grant", 64'(m_cmd_ready), 64'(2'b01 << (i % 2)));
         check("rr_addr", 64'(s_cmd_addr), 64'(addr_tab[i % 2]));
         for (int j = 0; j < NUM_M; j++) if (m_cmd_ready[j]) gnt_cnt[j]++;
         sb.push_back(i % 2);
         tick();
      end
      check("rr_share0", 64'(gnt_cnt[0]), 64'(2));
      check("rr_share1", 64'(gnt_cnt[1]), 64'(2));
      check("full_outs", 64'(outs_cnt), 64'(4));
      check("full_s_cmd_valid", 64'(s_cmd_valid), 64'(0));
      check("full_m_cmd_ready", 64'(m_cmd_ready), 64'(0));
      // One response while full: no push-through in the same cycle
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 32'h0000_00A0;
      #1;
      check("full_pop_cmd_blocked", 64'(s_cmd_valid), 64'(0));
      check("full_pop_route", 64'(m_rsp_valid), 64'(2'b01 << sb.pop_front()));
      tick();
      s_rsp_valid = 1'b0;
      check("full_outs_3", 64'(outs_cnt), 64'(3));
      check("full_resume_ready", 64'(m_cmd_ready), 64'(2'b01));
      sb.push_back(0);
      tick();
      m_cmd_valid = '0;
      check("full_outs_4", 64'(outs_cnt), 64'(4));
      for (int i = 0; i < 4; i++) respond(32'hC000_0000 + 32'(i));
      check("drain_outs", 64'(outs_cnt), 64'(0));

      // Lock under backpressure; rr_ptr now favours requester 1
      set_req(0, 1'b0, 32'hAAAA_0000, 32'h5555_0000);
      set_req(1, 1'b0, 32'hBBBB_0000, 32'h6666_0000);
      m_cmd_valid = 2'b01;
      s_cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("lock_addr", 64'(s_cmd_addr), 64'(32'hAAAA_0000));
         check("lock_wdata", 64'(s_cmd_wdata), 64'(32'h5555_0000));
         check("lock_valid", 64'(s_cmd_valid), 64'(1));
         tick();
         m_cmd_valid = 2'b11;
      end
      s_cmd_ready = 1'b1;
      #1;
      check("lock_hs_ready", 64'(m_cmd_ready), 64'(2'b01));
      sb.push_back(0);
      tick();
      m_cmd_valid = 2'b10;
      #1;
      check("lock_next_ready", 64'(m_cmd_ready), 64'(2'b10));
      check("lock_next_addr", 64'(s_cmd_addr), 64'(32'hBBBB_0000));
      sb.push_back(1);
      tick();
      m_cmd_valid = '0;
      respond(32'h0000_0A0A);
      respond(32'h0000_0B0B);

      // Interleaved routing with a stalled requester 1
      issue(0, 1'b1, 32'h0000_1000);
      issue(1, 1'b1, 32'h0000_2000);
      issue(0, 1'b1, 32'h0000_3000);
      check("il_outs_3", 64'(outs_cnt), 64'(3));
      m_rsp_ready = 2'b01;
      respond(32'h11);
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 32'h22;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("il_stall_valid", 64'(m_rsp_valid), 64'(2'b10));
         check("il_stall_ready", 64'(s_rsp_ready), 64'(0));
         tick();
         check("il_stall_outs", 64'(outs_cnt), 64'(2));
      end
      m_rsp_ready = 2'b11;
      respond(32'h22);
      respond(32'h33);
      check("il_outs_0", 64'(outs_cnt), 64'(0));

      // Reset with outstanding commands, then an unexpected response
      issue(0, 1'b0, 32'h0000_4000);
      issue(1, 1'b0, 32'h0000_5000);
      check("mid_outs_2", 64'(outs_cnt), 64'(2));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      check("mid_rst_outs", 64'(outs_cnt), 64'(0));
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 32'hFFFF_0000;
      #1;
      check("unexp_ready", 64'(s_rsp_ready), 64'(1));
      check("unexp_no_route", 64'(m_rsp_valid), 64'(0));
      check("unexp_pre", 64'(unexp_rsp), 64'(0));
      tick();
      s_rsp_valid = 1'b0;
      check("unexp_pulse", 64'(unexp_rsp), 64'(1));
      check("unexp_outs", 64'(outs_cnt), 64'(0));
      tick();
      check("unexp_clear", 64'(unexp_rsp), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
